// File: rtl/fixed_point_unit_pkg.sv
// Shared definitions for the fixed-point unit: opcodes, enable levels, FSM state encoding.
package fixed_point_unit_pkg;

  localparam logic [1:0] FPU_ADD  = 2'b00;
  localparam logic [1:0] FPU_SUB  = 2'b01;
  localparam logic [1:0] FPU_MUL  = 2'b10;
  localparam logic [1:0] FPU_SQRT = 2'b11;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MUL_BUSY  = 2'b01,
    SQRT_BUSY = 2'b10,
    DONE      = 2'b11
  } fpu_state_e;

endpackage

// File: rtl/fixed_point_unit_multiplier.sv
// Unsigned half-width partial-product multiplier, reused once per MUL_BUSY cycle.
module fpu_multiplier_16x16
  import fixed_point_unit_pkg::*;
#(
  parameter int HW = 16
) (
  input  logic [HW-1:0]   a_i,
  input  logic [HW-1:0]   b_i,
  output logic [2*HW-1:0] p_o
);

  assign p_o = {{HW{1'b0}}, a_i} * {{HW{1'b0}}, b_i};

endmodule

// File: rtl/fixed_point_unit.sv
// Fixed-point ADD/SUB (combinational), MUL and SQRT (multi-cycle) on Q(WIDTH-FBITS).FBITS values.
// Define FIXED_POINT_UNIT_SATURATE_EN to clamp ADD/SUB/MUL on overflow instead of wrapping.
module fixed_point_unit
  import fixed_point_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic [1:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             ready
);

  localparam int HW       = WIDTH / 2;
  localparam int PW       = 2 * WIDTH;
  localparam int SQ_ITERS = (WIDTH + FBITS) / 2;
  localparam int RAD_W    = WIDTH + FBITS;
  localparam int REM_W    = SQ_ITERS + 4;
  localparam int CNT_W    = $clog2(SQ_ITERS);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef FIXED_POINT_UNIT_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  fpu_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    a_mag_q;
  logic [WIDTH-1:0]    b_mag_q;
  logic                neg_q;
  logic [PW-1:0]       acc_q;
  logic [RAD_W-1:0]    rad_q;
  logic [REM_W-1:0]    rem_q;
  logic [SQ_ITERS-1:0] root_q;
  logic [WIDTH-1:0]    result_q;

  logic [WIDTH-1:0]    addsub_raw_s;
  logic                b_sign_eff_s;
  logic                addsub_ovf_s;
  logic [WIDTH-1:0]    addsub_d;

  logic [HW-1:0]       mul_a_s;
  logic [HW-1:0]       mul_b_s;
  logic [WIDTH-1:0]    pp_s;
  logic [PW-1:0]       pp_ext_s;
  logic [PW-1:0]       acc_d;
  logic [PW-1:0]       prod_s;
  logic [PW-1:0]       prod_sh_s;
  logic                mul_ovf_s;
  logic [WIDTH-1:0]    mul_d;

  logic [REM_W+1:0]    rem_sh_s;
  logic [REM_W+1:0]    trial_s;
  logic                sqrt_ge_s;
  logic [WIDTH-1:0]    sqrt_d;

  // Subtraction overflows like an addition of the negated operand, hence the flipped sign.
  always_comb begin
    addsub_raw_s = (operation == FPU_SUB) ? (operand_1 - operand_2) : (operand_1 + operand_2);
    b_sign_eff_s = (operation == FPU_SUB) ? ~operand_2[WIDTH-1] : operand_2[WIDTH-1];
    addsub_ovf_s = (operand_1[WIDTH-1] == b_sign_eff_s) && (addsub_raw_s[WIDTH-1] != operand_1[WIDTH-1]);
    if (SAT_EN && addsub_ovf_s) begin
      addsub_d = operand_1[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end else begin
      addsub_d = addsub_raw_s;
    end
  end

  fpu_multiplier_16x16 #(.HW(HW)) u_mul (
    .a_i (mul_a_s),
    .b_i (mul_b_s),
    .p_o (pp_s)
  );

  // Partial product order: lo*lo, lo*hi, hi*lo, hi*hi, each aligned before accumulation.
  always_comb begin
    mul_a_s  = a_mag_q[HW-1:0];
    mul_b_s  = b_mag_q[HW-1:0];
    pp_ext_s = PW'(pp_s);
    case (cnt_q[1:0])
      2'd0: begin
        mul_a_s  = a_mag_q[HW-1:0];
        mul_b_s  = b_mag_q[HW-1:0];
        pp_ext_s = PW'(pp_s);
      end
      2'd1: begin
        mul_a_s  = a_mag_q[HW-1:0];
        mul_b_s  = b_mag_q[WIDTH-1:HW];
        pp_ext_s = PW'(pp_s) << HW;
      end
      2'd2: begin
        mul_a_s  = a_mag_q[WIDTH-1:HW];
        mul_b_s  = b_mag_q[HW-1:0];
        pp_ext_s = PW'(pp_s) << HW;
      end
      default: begin
        mul_a_s  = a_mag_q[WIDTH-1:HW];
        mul_b_s  = b_mag_q[WIDTH-1:HW];
        pp_ext_s = PW'(pp_s) << WIDTH;
      end
    endcase
    acc_d     = acc_q + pp_ext_s;
    prod_s    = neg_q ? -acc_d : acc_d;
    prod_sh_s = $signed(prod_s) >>> FBITS;
    mul_ovf_s = ~((&prod_sh_s[PW-1:WIDTH-1]) | ~(|prod_sh_s[PW-1:WIDTH-1]));
    if (SAT_EN && mul_ovf_s) begin
      mul_d = prod_sh_s[PW-1] ? SAT_MIN : SAT_MAX;
    end else begin
      mul_d = prod_sh_s[WIDTH-1:0];
    end
  end

  // One restoring square-root digit: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    rem_sh_s  = {rem_q, rad_q[RAD_W-1 -: 2]};
    trial_s   = (REM_W + 2)'({root_q, 2'b01});
    sqrt_ge_s = (rem_sh_s >= trial_s);
    sqrt_d    = WIDTH'({root_q[SQ_ITERS-2:0], sqrt_ge_s});
  end

  // Control FSM plus the multi-cycle datapath registers it sequences.
  always_ff @(posedge clk or posedge reset) begin
    if (reset == ENABLE) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          acc_q  <= '0;
          rem_q  <= '0;
          root_q <= '0;
          case (operation)
            FPU_ADD, FPU_SUB: begin
              result_q <= addsub_d;
            end
            FPU_MUL: begin
              a_mag_q <= operand_1[WIDTH-1] ? -operand_1 : operand_1;
              b_mag_q <= operand_2[WIDTH-1] ? -operand_2 : operand_2;
              neg_q   <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
              state_q <= MUL_BUSY;
            end
            FPU_SQRT: begin
              rad_q   <= {operand_1, {FBITS{1'b0}}};
              state_q <= SQRT_BUSY;
            end
            default: begin
              state_q <= IDLE;
            end
          endcase
        end
        MUL_BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) begin
            result_q <= mul_d;
            state_q  <= DONE;
          end
        end
        SQRT_BUSY: begin
          rem_q  <= sqrt_ge_s ? REM_W'(rem_sh_s - trial_s) : rem_sh_s[REM_W-1:0];
          root_q <= {root_q[SQ_ITERS-2:0], sqrt_ge_s};
          rad_q  <= rad_q << 2;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SQ_ITERS - 1)) begin
            result_q <= sqrt_d;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ADD/SUB bypass the register so they answer in the same cycle; everything else shows result_q.
  always_comb begin
    result = result_q;
    ready  = DISABLE;
    if (reset == DISABLE) begin
      if ((state_q == IDLE) && ((operation == FPU_ADD) || (operation == FPU_SUB))) begin
        result = addsub_d;
        ready  = ENABLE;
      end else if (state_q == DONE) begin
        ready = ENABLE;
      end else begin
        ready = DISABLE;
      end
    end else begin
      ready = DISABLE;
    end
  end

endmodule

// File: tb/tb_fixed_point_unit.sv
// Directed self-checking bench for fixed_point_unit; expectations follow FIXED_POINT_UNIT_SATURATE_EN.
module tb_fixed_point_unit;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_SQRT = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] operand_1 = 32'h0;
  logic [31:0] operand_2 = 32'h0;
  logic [1:0]  operation = OP_SQRT;
  logic [31:0] result;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;

  fixed_point_unit #(.WIDTH(32), .FBITS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .operation (operation),
    .result    (result),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic comb_case(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res);
    operation = op;
    operand_1 = a;
    operand_2 = b;
    #1;
    n_cmp++;
    if (result !== exp_res) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", name, result, exp_res);
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready: got %b want 1", name, ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic multi_case(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_busy, input logic [31:0] exp_res,
                            input bit z_busy);
    int busy;
    operation = op;
    operand_1 = a;
    operand_2 = b;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s start_ready: got %b want 0", name, ready);
    end
    @(posedge clk);
    #1;
    if (z_busy) begin
      operation = 2'bzz;
      operand_1 = 32'hzzzzzzzz;
      operand_2 = 32'hzzzzzzzz;
    end
    busy = 0;
    while (ready !== 1'b1 && busy < 64) begin
      busy++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (busy !== exp_busy) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy, exp_busy);
    end
    n_cmp++;
    if (result !== exp_res) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", name, result, exp_res);
    end
    operation = op;
    operand_1 = a;
    operand_2 = b;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s pulse_width: ready got %b want 0", name, ready);
    end
    n_cmp++;
    if (result !== exp_res) begin
      n_err++;
      $display("FAIL %s hold: got %h want %h", name, result, exp_res);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    operation = OP_SQRT;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_result: got %h want 00000000", result);
    end
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 0", ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_add_sub();
    comb_case("add_basic", OP_ADD, 32'h00000E80, 32'h00001040, 32'h00001EC0);
    comb_case("sub_pos",   OP_SUB, 32'h00000E80, 32'h00000600, 32'h00000880);
    comb_case("sub_neg",   OP_SUB, 32'h00000600, 32'h00000E80, 32'hFFFFF780);
    comb_case("add_zero",  OP_ADD, 32'hFFFFF780, 32'h00000880, 32'h00000000);
  endtask

  task automatic test_mul();
    multi_case("mul_basic", OP_MUL, 32'h00000E80, 32'h00000600, 4, 32'h000015C0, 1'b1);
    multi_case("mul_neg",   OP_MUL, 32'hFFFFFA00, 32'h00000E80, 4, 32'hFFFFEA40, 1'b0);
    multi_case("mul_hihi",  OP_MUL, 32'h00020000, 32'h00020000, 4, 32'h01000000, 1'b0);
    multi_case("mul_hilo",  OP_MUL, 32'h00010400, 32'h00000C00, 4, 32'h00030C00, 1'b0);
    multi_case("mul_lohi",  OP_MUL, 32'h00000C00, 32'h00010400, 4, 32'h00030C00, 1'b1);
  endtask

  task automatic test_sqrt();
    multi_case("sqrt_115",  OP_SQRT, 32'h0001CC00, 32'h0, 21, 32'h00002AE5, 1'b1);
    multi_case("sqrt_zero", OP_SQRT, 32'h00000000, 32'h0, 21, 32'h00000000, 1'b0);
    multi_case("sqrt_4",    OP_SQRT, 32'h00001000, 32'h0, 21, 32'h00000800, 1'b0);
    multi_case("sqrt_max",  OP_SQRT, 32'hFFFFFFFF, 32'h0, 21, 32'h001FFFFF, 1'b0);
  endtask

  task automatic test_overflow();
`ifdef FIXED_POINT_UNIT_SATURATE_EN
    comb_case("add_ovf", OP_ADD, 32'h7FFFFC00, 32'h00000400, 32'h7FFFFFFF);
    comb_case("sub_ovf", OP_SUB, 32'h80000000, 32'h00000400, 32'h80000000);
    multi_case("mul_ovf", OP_MUL, 32'h7FFFFFFF, 32'h00000C00, 4, 32'h7FFFFFFF, 1'b0);
`else
    comb_case("add_ovf", OP_ADD, 32'h7FFFFC00, 32'h00000400, 32'h80000000);
    comb_case("sub_ovf", OP_SUB, 32'h80000000, 32'h00000400, 32'h7FFFFC00);
    multi_case("mul_ovf", OP_MUL, 32'h7FFFFFFF, 32'h00000C00, 4, 32'h7FFFFFFD, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_sqrt();
    operation = OP_SQRT;
    operand_1 = 32'h0001CC00;
    operand_2 = 32'h0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (result !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_result: got %h want 00000000", result);
    end
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_ready: got %b want 0", ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    multi_case("sqrt_after_reset", OP_SQRT, 32'h00001000, 32'h0, 21, 32'h00000800, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_sqrt();
    test_overflow();
    test_reset_mid_sqrt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
